// File: rtl/md_pkg.sv
// Shared op codes, default latencies and FSM encoding for the E-stage multiply/divide issue logic.
package md_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTLO  = 4'd5;
  localparam logic [3:0] MD_MTHI  = 4'd6;
  localparam logic [3:0] MD_MF    = 4'd7;
  localparam logic [3:0] MD_SWAP  = 4'd8;

  localparam int unsigned MUL_CYCLES_DFLT = 5;
  localparam int unsigned DIV_CYCLES_DFLT = 10;

  typedef enum logic [1:0] {StIdle, StMul, StDiv} md_state_e;

  // Codes 9..15 are not MD-class: they never stall and never start the unit.
  function automatic logic is_md_op(input logic [3:0] op);
    return (op >= MD_MULT) && (op <= MD_SWAP);
  endfunction

  function automatic logic is_start_op(input logic [3:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Loadable down-counter that stops at zero; busy flags a nonzero count.
module md_busy_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             busy
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign cnt  = cnt_q;
  assign busy = (cnt_q != '0);

endmodule

// File: rtl/md_issue_ctrl.sv
// Registers the MD op from D into E, tracks the unit's busy window and stalls D on MD hazards.
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DFLT,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DFLT,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned STAT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        D_MDOp,
  input  logic              D_Valid,
  input  logic              E_Clear,
  output logic [3:0]        E_MDControl,
  output logic              Start,
  output logic              Busy,
  output logic              D_Stall,
  output logic [STAT_W-1:0] StallCnt
);

  md_state_e        state_q, state_d;
  logic [3:0]       e_op_q;
  logic [STAT_W-1:0] stall_cnt_q;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] cnt;
  logic             busy;

  md_busy_counter #(
    .CNT_W (CNT_W)
  ) u_busy_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .cnt      (cnt),
    .busy     (busy)
  );

  assign E_MDControl = e_op_q;
  assign Busy        = busy;
  assign Start       = is_start_op(e_op_q) && !busy;
  // HI/LO accesses must also wait for the result, so every MD-class op stalls.
  assign D_Stall     = D_Valid && is_md_op(D_MDOp) && (Start || busy);
  assign StallCnt    = stall_cnt_q;

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = '0;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          load = 1'b1;
          if (is_mul_op(e_op_q)) begin
            state_d  = StMul;
            load_val = CNT_W'(MUL_CYCLES);
          end else begin
            state_d  = StDiv;
            load_val = CNT_W'(DIV_CYCLES);
          end
        end
      end
      StMul, StDiv: begin
        // Leave on the edge that loads zero into the counter.
        if (cnt <= CNT_W'(1)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_op_q <= MD_NONE;
    end else if (E_Clear || D_Stall) begin
      e_op_q <= MD_NONE;
    end else begin
      e_op_q <= D_Valid ? D_MDOp : MD_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (D_Stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl; a second instance with a 4-bit statistic checks saturation.
module tb_md_issue_ctrl;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  D_MDOp;
  logic        D_Valid;
  logic        E_Clear;
  logic [3:0]  E_MDControl, E_MDControl4;
  logic        Start, Start4;
  logic        Busy, Busy4;
  logic        D_Stall, D_Stall4;
  logic [15:0] StallCnt;
  logic [3:0]  StallCnt4;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  md_issue_ctrl #(
    .MUL_CYCLES (5),
    .DIV_CYCLES (10),
    .CNT_W      (4),
    .STAT_W     (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .D_MDOp      (D_MDOp),
    .D_Valid     (D_Valid),
    .E_Clear     (E_Clear),
    .E_MDControl (E_MDControl),
    .Start       (Start),
    .Busy        (Busy),
    .D_Stall     (D_Stall),
    .StallCnt    (StallCnt)
  );

  md_issue_ctrl #(
    .MUL_CYCLES (5),
    .DIV_CYCLES (10),
    .CNT_W      (4),
    .STAT_W     (4)
  ) dut4 (
    .clk         (clk),
    .reset       (reset),
    .D_MDOp      (D_MDOp),
    .D_Valid     (D_Valid),
    .E_Clear     (E_Clear),
    .E_MDControl (E_MDControl4),
    .Start       (Start4),
    .Busy        (Busy4),
    .D_Stall     (D_Stall4),
    .StallCnt    (StallCnt4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one cycle and check that nothing starts while the unit is busy.
  task automatic cyc();
    @(posedge clk);
    #1;
    chk("inv_start_while_busy",
        32'((E_MDControl >= 4'd1) && (E_MDControl <= 4'd4) && Busy), 32'd0);
  endtask

  task automatic drive(input logic [3:0] op, input logic v, input logic clr);
    D_MDOp  = op;
    D_Valid = v;
    E_Clear = clr;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(MD_NONE, 1'b0, 1'b0);
    cyc();
    cyc();
    chk("rst_e", 32'(E_MDControl), 32'd0);
    chk("rst_start", 32'(Start), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_stall", 32'(D_Stall), 32'd0);
    chk("rst_cnt", 32'(StallCnt), 32'd0);
    reset = 1'b0;

    // Lone mult: one Start cycle, five busy cycles.
    drive(MD_MULT, 1'b1, 1'b0);
    chk("mul_d_nostall", 32'(D_Stall), 32'd0);
    cyc();
    drive(MD_NONE, 1'b0, 1'b0);
    chk("mul_e", 32'(E_MDControl), 32'd1);
    chk("mul_start", 32'(Start), 32'd1);
    chk("mul_busy_t1", 32'(Busy), 32'd0);
    cyc();
    chk("mul_start_t2", 32'(Start), 32'd0);
    chk("mul_e_t2", 32'(E_MDControl), 32'd0);
    chk("mul_busy_t2", 32'(Busy), 32'd1);
    for (int k = 3; k <= 6; k++) begin
      cyc();
      chk("mul_busy_win", 32'(Busy), 32'd1);
    end
    cyc();
    chk("mul_busy_t7", 32'(Busy), 32'd0);
    chk("mul_start_t7", 32'(Start), 32'd0);
    chk("mul_statcnt", 32'(StallCnt), 32'd0);

    // mult followed by mflo: mflo stalls through the Start cycle and the whole busy window.
    drive(MD_MULT, 1'b1, 1'b0);
    cyc();
    drive(MD_MF, 1'b1, 1'b0);
    chk("mf_stall_t1", 32'(D_Stall), 32'd1);
    chk("mf_start_t1", 32'(Start), 32'd1);
    for (int k = 2; k <= 6; k++) begin
      cyc();
      chk("mf_stall_win", 32'(D_Stall), 32'd1);
      chk("mf_busy_win", 32'(Busy), 32'd1);
      chk("mf_e_bubble", 32'(E_MDControl), 32'd0);
    end
    cyc();
    chk("mf_stall_t7", 32'(D_Stall), 32'd0);
    chk("mf_busy_t7", 32'(Busy), 32'd0);
    chk("mf_statcnt", 32'(StallCnt), 32'd6);
    cyc();
    drive(MD_NONE, 1'b0, 1'b0);
    chk("mf_e_entered", 32'(E_MDControl), 32'd7);
    chk("mf_no_start", 32'(Start), 32'd0);

    // divu then div back to back: div waits out eleven stall cycles.
    cyc();
    drive(MD_DIVU, 1'b1, 1'b0);
    cyc();
    drive(MD_DIV, 1'b1, 1'b0);
    chk("dd_start1", 32'(Start), 32'd1);
    chk("dd_e1", 32'(E_MDControl), 32'd4);
    chk("dd_stall_t1", 32'(D_Stall), 32'd1);
    for (int k = 2; k <= 11; k++) begin
      cyc();
      chk("dd_busy_win", 32'(Busy), 32'd1);
      chk("dd_no_start", 32'(Start), 32'd0);
      chk("dd_stall_win", 32'(D_Stall), 32'd1);
    end
    cyc();
    chk("dd_busy_t12", 32'(Busy), 32'd0);
    chk("dd_stall_t12", 32'(D_Stall), 32'd0);
    chk("dd_statcnt16", 32'(StallCnt), 32'd17);
    chk("dd_statcnt4_sat", 32'(StallCnt4), 32'd15);
    cyc();
    drive(MD_NONE, 1'b1, 1'b0);
    chk("dd_e2", 32'(E_MDControl), 32'd3);
    chk("dd_start2", 32'(Start), 32'd1);
    chk("dd_add_nostall_start", 32'(D_Stall), 32'd0);
    cyc();
    chk("dd_add_busy", 32'(Busy), 32'd1);
    chk("dd_add_nostall", 32'(D_Stall), 32'd0);
    cyc();
    drive(4'd9, 1'b1, 1'b0);
    chk("dd_op9_nostall", 32'(D_Stall), 32'd0);
    cyc();
    drive(MD_NONE, 1'b0, 1'b0);
    chk("dd_op9_in_e", 32'(E_MDControl), 32'd9);
    chk("dd_op9_no_start", 32'(Start), 32'd0);
    for (int k = 17; k <= 23; k++) begin
      cyc();
      chk("dd_busy2_win", 32'(Busy), 32'd1);
    end
    cyc();
    chk("dd_busy2_done", 32'(Busy), 32'd0);
    chk("dd_statcnt_hold", 32'(StallCnt), 32'd17);

    // HI/LO moves and plain ops while idle never stall; E_Clear squashes E.
    cyc();
    drive(MD_MTLO, 1'b1, 1'b0);
    chk("mtlo_nostall", 32'(D_Stall), 32'd0);
    cyc();
    drive(MD_NONE, 1'b1, 1'b0);
    chk("mtlo_e", 32'(E_MDControl), 32'd5);
    chk("mtlo_no_start", 32'(Start), 32'd0);
    chk("mtlo_no_busy", 32'(Busy), 32'd0);
    chk("add_nostall", 32'(D_Stall), 32'd0);
    cyc();
    drive(MD_MTHI, 1'b1, 1'b1);
    chk("add_busy", 32'(Busy), 32'd0);
    cyc();
    drive(MD_NONE, 1'b0, 1'b0);
    chk("clear_e", 32'(E_MDControl), 32'd0);

    // E_Clear during a div does not abort it; clear plus stall still counts.
    cyc();
    drive(MD_DIV, 1'b1, 1'b0);
    cyc();
    drive(MD_NONE, 1'b0, 1'b0);
    chk("clr_start", 32'(Start), 32'd1);
    cyc();
    cyc();
    cyc();
    drive(MD_MF, 1'b1, 1'b1);
    chk("clr_stall", 32'(D_Stall), 32'd1);
    chk("clr_busy_t4", 32'(Busy), 32'd1);
    cyc();
    drive(MD_NONE, 1'b0, 1'b0);
    chk("clr_e_bubble", 32'(E_MDControl), 32'd0);
    chk("clr_busy_t5", 32'(Busy), 32'd1);
    chk("clr_statcnt", 32'(StallCnt), 32'd18);
    for (int k = 6; k <= 11; k++) begin
      cyc();
      chk("clr_busy_win", 32'(Busy), 32'd1);
    end
    cyc();
    chk("clr_busy_done", 32'(Busy), 32'd0);

    // Reset mid-countdown clears everything on the next edge.
    cyc();
    drive(MD_DIV, 1'b1, 1'b0);
    cyc();
    drive(MD_NONE, 1'b0, 1'b0);
    cyc();
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    chk("mrst_busy", 32'(Busy), 32'd0);
    chk("mrst_e", 32'(E_MDControl), 32'd0);
    chk("mrst_start", 32'(Start), 32'd0);
    chk("mrst_cnt16", 32'(StallCnt), 32'd0);
    chk("mrst_cnt4", 32'(StallCnt4), 32'd0);

    // Unit issues normally after reset.
    drive(MD_MULTU, 1'b1, 1'b0);
    cyc();
    drive(MD_NONE, 1'b0, 1'b0);
    chk("post_e", 32'(E_MDControl), 32'd2);
    chk("post_start", 32'(Start), 32'd1);
    cyc();
    chk("post_busy", 32'(Busy), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
